// File: rtl/exec_mon_if.sv
// Register bus between the SoC interconnect and the execution monitor.
interface exec_mon_if;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (output cs, we, address, write_data, input read_data, ready);
   modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/exec_mon.sv
// CPU execution monitor: traps instruction fetches from firmware RAM or from
// lockable software windows, logs the first offender and drives the trap LED.
module exec_mon #(
   parameter int          NUM_REGIONS  = 4,
   parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
   parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff,
   parameter int          BLINK_W      = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_valid,
   input  logic        cpu_instr,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_trap,
   output logic        force_trap,
   output logic [2:0]  trap_led,
   exec_mon_if.slave   bus
);

   localparam logic [31:0] NAME_WORD = 32'h6d6f6e31;

   logic [NUM_REGIONS-1:0] enable_mask;
   logic [31:0]            first_addr [NUM_REGIONS];
   logic [31:0]            last_addr  [NUM_REGIONS];
   logic [31:0]            viol_addr;
   logic [15:0]            viol_count;
   logic [BLINK_W-1:0]     blink_ctr;
   logic                   blink_r;
   logic [7:0]             enable_ext;
   logic                   window_hit;
   logic                   fw_hit;
   logic                   hit;
   logic                   wr_en;
   logic [31:0]            rdata;

   function automatic logic [7:0] first_reg(input int idx);
      return 8'(16 + 2 * idx);
   endfunction

   function automatic logic [7:0] last_reg(input int idx);
      return 8'(17 + 2 * idx);
   endfunction

   assign enable_ext = 8'(enable_mask);
   assign wr_en      = bus.cs && bus.we;

   // An inverted window (first > last) can never satisfy both bounds, so it needs no special case.
   always_comb begin
      window_hit = 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (enable_mask[i] && (cpu_addr >= first_addr[i]) && (cpu_addr <= last_addr[i]))
            window_hit = 1'b1;
      end
   end

   assign fw_hit = (cpu_addr >= FW_RAM_FIRST) && (cpu_addr <= FW_RAM_LAST);
   assign hit    = cpu_valid && cpu_instr && (fw_hit || window_hit);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable_mask <= '0;
         viol_addr   <= '0;
         viol_count  <= '0;
         force_trap  <= 1'b0;
         blink_ctr   <= '0;
         blink_r     <= 1'b0;
         for (int i = 0; i < NUM_REGIONS; i++) begin
            first_addr[i] <= '0;
            last_addr[i]  <= '0;
         end
      end else begin
         if (hit) begin
            force_trap <= 1'b1;
            if (!force_trap)
               viol_addr <= cpu_addr;
            if (viol_count != 16'hffff)
               viol_count <= viol_count + 16'd1;
         end

         // Enable bits only ever set; once set they also freeze that window's bounds.
         if (wr_en && (bus.address == 8'h04))
            enable_mask <= enable_mask | bus.write_data[NUM_REGIONS-1:0];

         for (int i = 0; i < NUM_REGIONS; i++) begin
            if (wr_en && !enable_mask[i]) begin
               if (bus.address == first_reg(i))
                  first_addr[i] <= bus.write_data;
               if (bus.address == last_reg(i))
                  last_addr[i] <= bus.write_data;
            end
         end

         blink_ctr <= blink_ctr + BLINK_W'(1);
         if (blink_ctr == '0)
            blink_r <= ~blink_r;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.cs && !bus.we) begin
         case (bus.address)
            8'h00:   rdata = NAME_WORD;
            8'h01:   rdata = {16'h0000, enable_ext, 7'b0000000, force_trap};
            8'h02:   rdata = viol_addr;
            8'h03:   rdata = {16'h0000, viol_count};
            8'h04:   rdata = {24'h000000, enable_ext};
            default: begin
               for (int i = 0; i < NUM_REGIONS; i++) begin
                  if (bus.address == first_reg(i))
                     rdata = first_addr[i];
                  if (bus.address == last_reg(i))
                     rdata = last_addr[i];
               end
            end
         endcase
      end
   end

   assign bus.read_data = rdata;
   assign bus.ready     = bus.cs;
   assign trap_led      = cpu_trap ? {blink_r, 2'b00} : 3'b000;

endmodule

// File: tb/tb_exec_mon.sv
// Directed, table-driven bench for exec_mon with a short blink counter.
module tb_exec_mon;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_valid;
   logic        cpu_instr;
   logic [31:0] cpu_addr;
   logic        cpu_trap;
   logic        force_trap;
   logic [2:0]  trap_led;

   int checks = 0;
   int errors = 0;

   exec_mon_if bus_if ();

   exec_mon #(
      .NUM_REGIONS (4),
      .FW_RAM_FIRST(32'hd0000000),
      .FW_RAM_LAST (32'hd00007ff),
      .BLINK_W     (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_valid (cpu_valid),
      .cpu_instr (cpu_instr),
      .cpu_addr  (cpu_addr),
      .cpu_trap  (cpu_trap),
      .force_trap(force_trap),
      .trap_led  (trap_led),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp_data;
   } reg_vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        exp_trap;
      logic [15:0] exp_count;
   } fetch_vec_t;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
      bus_if.cs         = 1'b1;
      bus_if.we         = 1'b1;
      bus_if.address    = addr;
      bus_if.write_data = data;
      @(posedge clk);
      #1;
      bus_if.cs = 1'b0;
      bus_if.we = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [7:0] addr, input logic [31:0] expected);
      bus_if.cs      = 1'b1;
      bus_if.we      = 1'b0;
      bus_if.address = addr;
      #1;
      check_output(name, bus_if.read_data, expected);
      bus_if.cs = 1'b0;
      #1;
   endtask

   // One CPU access cycle; results are sampled just after the closing edge.
   task automatic apply_stimulus(input logic valid, input logic instr, input logic [31:0] addr);
      cpu_valid = valid;
      cpu_instr = instr;
      cpu_addr  = addr;
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      cpu_instr = 1'b0;
   endtask

   initial begin
      reg_vec_t   reset_regs [5];
      fetch_vec_t win_fetches [4];
      logic [2:0] exp_led;

      reset_regs[0] = '{8'h00, 32'h6d6f6e31};
      reset_regs[1] = '{8'h01, 32'h0};
      reset_regs[2] = '{8'h02, 32'h0};
      reset_regs[3] = '{8'h03, 32'h0};
      reset_regs[4] = '{8'h04, 32'h0};

      win_fetches[0] = '{32'h40000ffc, 1'b0, 16'd0};
      win_fetches[1] = '{32'h40001000, 1'b1, 16'd1};
      win_fetches[2] = '{32'h40001fff, 1'b1, 16'd2};
      win_fetches[3] = '{32'h40002000, 1'b1, 16'd2};

      reset_n           = 1'b0;
      cpu_valid         = 1'b0;
      cpu_instr         = 1'b0;
      cpu_addr          = '0;
      cpu_trap          = 1'b0;
      bus_if.cs         = 1'b0;
      bus_if.we         = 1'b0;
      bus_if.address    = '0;
      bus_if.write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      foreach (reset_regs[i])
         read_check($sformatf("reset_reg_%0h", reset_regs[i].addr), reset_regs[i].addr, reset_regs[i].exp_data);
      check_output("reset_force_trap", 32'(force_trap), 32'd0);
      check_output("reset_trap_led", 32'(trap_led), 32'd0);
      bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = 8'h00;
      #1;
      check_output("ready_follows_cs", 32'(bus_if.ready), 32'd1);
      check_output("read_zero_on_write", bus_if.read_data, 32'd0);
      bus_if.cs = 1'b0; bus_if.we = 1'b0;
      #1;
      check_output("ready_low_no_cs", 32'(bus_if.ready), 32'd0);

      // Firmware RAM fetches
      apply_stimulus(1'b1, 1'b0, 32'hd0000400);
      check_output("fw_nonfetch_trap", 32'(force_trap), 32'd0);
      apply_stimulus(1'b0, 1'b1, 32'hd0000400);
      check_output("fw_invalid_trap", 32'(force_trap), 32'd0);
      cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'hd0000400;
      #1;
      check_output("fw_trap_latency", 32'(force_trap), 32'd0);
      @(posedge clk);
      #1;
      cpu_valid = 1'b0; cpu_instr = 1'b0;
      check_output("fw_trap_set", 32'(force_trap), 32'd1);
      read_check("fw_viol_addr", 8'h02, 32'hd0000400);
      read_check("fw_viol_count", 8'h03, 32'd1);
      apply_stimulus(1'b1, 1'b0, 32'hd0000400);
      read_check("fw_nonfetch_count", 8'h03, 32'd1);
      apply_stimulus(1'b1, 1'b1, 32'hd00007ff);
      read_check("fw_last_count", 8'h03, 32'd2);
      apply_stimulus(1'b1, 1'b1, 32'hd0000800);
      read_check("fw_past_last_count", 8'h03, 32'd2);
      read_check("fw_viol_addr_kept", 8'h02, 32'hd0000400);
      read_check("fw_status", 8'h01, 32'h1);

      // Software window 1
      do_reset();
      bus_write(8'h12, 32'h40001000);
      bus_write(8'h13, 32'h40001fff);
      read_check("win1_first", 8'h12, 32'h40001000);
      read_check("win1_last", 8'h13, 32'h40001fff);
      apply_stimulus(1'b1, 1'b1, 32'h40001000);
      check_output("win1_disabled_trap", 32'(force_trap), 32'd0);
      bus_write(8'h04, 32'hf0);
      read_check("enable_high_bits_dropped", 8'h04, 32'h0);
      bus_write(8'h04, 32'h2);
      read_check("win1_enable", 8'h04, 32'h2);
      read_check("win1_status", 8'h01, 32'h0200);
      foreach (win_fetches[i]) begin
         apply_stimulus(1'b1, 1'b1, win_fetches[i].addr);
         check_output($sformatf("win1_trap_%0d", i), 32'(force_trap), 32'(win_fetches[i].exp_trap));
         read_check($sformatf("win1_count_%0d", i), 8'h03, 32'(win_fetches[i].exp_count));
      end
      read_check("win1_viol_addr", 8'h02, 32'h40001000);
      bus_write(8'h12, 32'h0);
      read_check("win1_first_locked", 8'h12, 32'h40001000);
      bus_write(8'h04, 32'h0);
      read_check("enable_not_clearable", 8'h04, 32'h2);
      bus_write(8'h1a, 32'h12345678);
      read_check("region5_reads_zero", 8'h1a, 32'h0);
      read_check("unmapped_reads_zero", 8'h05, 32'h0);

      // Enable write racing a fetch
      do_reset();
      bus_write(8'h10, 32'h00001000);
      bus_write(8'h11, 32'h00001000);
      bus_write(8'h14, 32'h00003000);
      bus_write(8'h15, 32'h00002000);
      bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.address = 8'h04; bus_if.write_data = 32'h1;
      apply_stimulus(1'b1, 1'b1, 32'h00001000);
      bus_if.cs = 1'b0; bus_if.we = 1'b0;
      check_output("race_old_mask_no_trap", 32'(force_trap), 32'd0);
      apply_stimulus(1'b1, 1'b1, 32'h00001000);
      check_output("race_next_cycle_trap", 32'(force_trap), 32'd1);
      read_check("race_viol_addr", 8'h02, 32'h00001000);
      bus_write(8'h04, 32'h4);
      apply_stimulus(1'b1, 1'b1, 32'h00002800);
      apply_stimulus(1'b1, 1'b1, 32'h00003000);
      read_check("inverted_window_count", 8'h03, 32'd1);
      read_check("race_status", 8'h01, 32'h0501);

      // Counter saturation with back-to-back hits
      do_reset();
      cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'hd0000004;
      @(posedge clk);
      #1;
      cpu_addr = 32'hd0000008;
      repeat (65533) @(posedge clk);
      #1;
      read_check("sat_count_fffe", 8'h03, 32'h0000fffe);
      @(posedge clk);
      #1;
      read_check("sat_count_plus1", 8'h03, 32'h0000ffff);
      repeat (2) @(posedge clk);
      #1;
      read_check("sat_count_plus3", 8'h03, 32'h0000ffff);
      read_check("sat_viol_addr_first", 8'h02, 32'hd0000004);
      cpu_valid = 1'b0; cpu_instr = 1'b0;

      // Blink pattern: 16 cycles per toggle, first toggle to 1 right after reset
      do_reset();
      cpu_trap = 1'b1;
      #1;
      check_output("blink_after_reset", 32'(trap_led), 32'd0);
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         exp_led = (((k - 1) >> 4) & 1) == 0 ? 3'b100 : 3'b000;
         check_output($sformatf("blink_k%0d", k), 32'(trap_led), 32'(exp_led));
      end
      cpu_trap = 1'b0;
      #1;
      check_output("blink_trap_dropped", 32'(trap_led), 32'd0);

      // Reset mid-operation
      bus_write(8'h04, 32'h3);
      apply_stimulus(1'b1, 1'b1, 32'hd0000000);
      check_output("midreset_trap_before", 32'(force_trap), 32'd1);
      do_reset();
      check_output("midreset_trap_cleared", 32'(force_trap), 32'd0);
      read_check("midreset_enable", 8'h04, 32'h0);
      read_check("midreset_count", 8'h03, 32'h0);
      read_check("midreset_viol_addr", 8'h02, 32'h0);
      bus_write(8'h10, 32'h55);
      read_check("midreset_unlocked", 8'h10, 32'h55);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/exec_mon.md
# exec_mon

Parametrised CPU execution monitor and trap indicator for the tk1-family application FPGA. It sits next to the system core on the CPU memory bus and watches every instruction fetch. It raises a sticky `force_trap` when a fetch lands in firmware RAM or in any of `NUM_REGIONS` software-programmable, lockable address windows. It also records the first violating address, counts violations, and produces the blinking trap LED pattern.

## Interface
Parameters:
- `NUM_REGIONS`, 4 — number of monitored windows, 1..8.
- `FW_RAM_FIRST`, 32'hd0000000 — first address of the always-monitored firmware RAM.
- `FW_RAM_LAST`, 32'hd00007ff — last address of the always-monitored firmware RAM.
- `BLINK_W`, 24 — width of the trap blink counter.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `cpu_valid`  in  1  CPU memory access valid.
- `cpu_instr`  in  1  access is an instruction fetch.
- `cpu_addr`  in  32  CPU access address.
- `cpu_trap`  in  1  CPU is in trap state.
- `force_trap`  out  1  sticky trap request to the CPU.
- `trap_led`  out  3  {R,G,B} trap pattern; the parent selects it while `cpu_trap` is high.
- `cs`  in  1  bus select.
- `we`  in  1  bus write.
- `address`  in  8  word address.
- `write_data`  in  32  bus write data.
- `read_data`  out  32  bus read data.
- `ready`  out  1  bus ready.

## Operation
Register map (word addresses):
- 0x00 NAME: read-only constant 32'h6d6f6e31.
- 0x01 STATUS: read-only. Bit0 = `force_trap`. Bits[15:8] = region enable mask, zero-extended.
- 0x02 VIOL_ADDR: read-only address of the first violating fetch. Reads 0 until the first violation.
- 0x03 VIOL_COUNT: read-only, 16-bit, saturating at 16'hffff.
- 0x04 ENABLE: write only sets bits. The enable mask becomes `enable | write_data[NUM_REGIONS-1:0]`. No write can clear a bit. Reads return the mask.
- 0x10+2i FIRST_i and 0x11+2i LAST_i, for i < NUM_REGIONS: read/write. A write is ignored once `enable[i]` is 1.

Other rules:
- Addresses that are unmapped, and regions with index ≥ NUM_REGIONS, read 0. Writes to them are ignored.
- A hit is `cpu_valid && cpu_instr` with either of:
  - FW_RAM_FIRST ≤ `cpu_addr` ≤ FW_RAM_LAST, or
  - for some enabled i, FIRST_i ≤ `cpu_addr` ≤ LAST_i.
- All address comparisons are unsigned 32-bit.
- A region with FIRST_i > LAST_i never matches.
- On a hit:
  - `force_trap` is set and stays set until reset.
  - VIOL_ADDR captures `cpu_addr`, but only if `force_trap` was 0 in that cycle.
  - VIOL_COUNT increments unless it is at 16'hffff.
- A hit that is not a fetch (`cpu_instr` = 0) is ignored, as is any cycle with `cpu_valid` = 0.
- Blink logic:
  - `blink_ctr` (BLINK_W bits) free-runs and wraps.
  - When `blink_ctr` == 0, `blink_r` toggles.
  - `trap_led` = {`blink_r`, 2'b00} while `cpu_trap` is high, else 3'b000.
- Reset values:
  - `force_trap` = 0, `trap_led` = 0.
  - enable mask = 0, all FIRST/LAST = 0.
  - VIOL_ADDR = 0, VIOL_COUNT = 0.
  - `blink_ctr` = 0, `blink_r` = 0.

## Timing
Bus:
- `ready` = `cs`, combinational, in the same cycle.
- `read_data` is combinational. It is 0 when `cs` = 0 or `we` = 1.
- Writes take effect at the next clock edge.

Monitor:
- Hit detection is combinational on the registered enable mask and the registered windows.
- `force_trap` rises at the edge after the hit cycle, giving 1-cycle latency.
- VIOL_ADDR and VIOL_COUNT update at that same edge.

Boundary cases:
- Back-to-back hits: VIOL_COUNT increments every cycle, and VIOL_ADDR keeps the first address.
- ENABLE write and a matching fetch in the same cycle: that fetch uses the old mask and is not flagged. A matching fetch in the next cycle is flagged.
- FIRST_i write and ENABLE bit i in the same cycle (on different bus cycles, so only possible through separate writes): the write ordering decides. A FIRST write in the cycle before the enable is accepted.
- Window endpoints are inclusive: addr = FIRST_i and addr = LAST_i both hit.
- Blink: at first toggle, `blink_r` becomes 1 on the edge where `blink_ctr` goes from 0 to 1. The period is 2^BLINK_W cycles per toggle.
- Reset mid-operation clears all state, including a set `force_trap` and locked enables, at the next edge.

## Test plan
- Reset, then read 0x00–0x04 → 6d6f6e31, 0, 0, 0, 0. `force_trap` = 0 and `trap_led` = 0.
- Fetch at 32'hd0000400 → `force_trap` = 1 one cycle later, VIOL_ADDR = d0000400, VIOL_COUNT = 1. A non-fetch access at the same address produces no change.
- Program FIRST_1 = 0x40001000 and LAST_1 = 0x40001fff, then write ENABLE = 0x2.
  - Fetches at 0x40000ffc, 0x40001000, 0x40001fff and 0x40002000 hit only on the middle two.
  - VIOL_COUNT = 2, VIOL_ADDR = 0x40001000.
  - Writing FIRST_1 = 0 afterwards leaves it reading 0x40001000.
- Write ENABLE = 0x1 in the same cycle as a fetch inside window 0 → no trap. The same fetch one cycle later → trap.
- Preload VIOL_COUNT to 0xfffe by driving continuous hits → after 3 more hit cycles it reads 0xffff.
- With BLINK_W = 4 and `cpu_trap` = 1:
  - `trap_led` toggles between 3'b100 and 3'b000 every 16 cycles.
  - Dropping `cpu_trap` gives 3'b000 immediately.
  - Asserting `reset_n` = 0 for one cycle clears `force_trap` and the enables.
